// File: rtl/rvc_fetch_aligner.sv
// Fetch aligner: buffers 32-bit fetch words as halfwords, splits them into
// 16/32-bit instructions and expands the supported RVC subset to RV32I.
module rvc_fetch_aligner #(
    parameter int unsigned BUF_HW   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          RVC_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_data_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o,
    output logic        instr_illegal_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    localparam int PW = $clog2(BUF_HW);
    localparam int CW = PW + 1;

    logic [15:0]   hw_buf [BUF_HW];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pc;
    logic          skip_lo;

    logic [CW-1:0] free_hw;
    logic [15:0]   head0, head1;
    logic          head_is_c, has_instr;
    logic          fetch_fire, pop_fire;
    logic [1:0]    push_n, pop_n;
    logic [31:0]   dec_instr;
    logic          dec_illegal;

    logic [4:0]    rd_p, rs1_p, rd, rs2;

    assign free_hw    = CW'(BUF_HW) - count;
    assign head0      = hw_buf[rd_ptr];
    assign head1      = hw_buf[rd_ptr + PW'(1)];
    assign head_is_c  = RVC_EN && (head0[1:0] != 2'b11);
    assign has_instr  = head_is_c ? (count >= CW'(1)) : (count >= CW'(2));

    // Reset holds ready high even if a redirect is being driven.
    assign fetch_ready_o      = ~rst_n | ((free_hw >= CW'(2)) & ~redirect_i);
    assign instr_valid_o      = has_instr & ~redirect_i;
    assign instr_compressed_o = head_is_c;
    assign instr_illegal_o    = instr_valid_o & head_is_c & dec_illegal;
    assign instr_pc_o         = pc;
    assign instr_o            = !head_is_c  ? {head1, head0} :
                                dec_illegal ? {16'h0000, head0} : dec_instr;

    assign fetch_fire = fetch_valid_i & fetch_ready_o;
    assign pop_fire   = instr_valid_o & instr_ready_i;
    assign push_n     = !fetch_fire ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);
    assign pop_n      = !pop_fire ? 2'd0 : (head_is_c ? 2'd1 : 2'd2);

    assign rd_p  = {2'b01, head0[4:2]};
    assign rs1_p = {2'b01, head0[9:7]};
    assign rd    = head0[11:7];
    assign rs2   = head0[6:2];

    // Expansion builds the RV32I immediates straight from the RVC bit positions.
    always_comb begin
        dec_instr   = 32'h0000_0000;
        dec_illegal = 1'b1;
        unique case (head0[1:0])
            2'b00: begin
                if (head0[15:13] == 3'b010) begin
                    dec_instr   = {5'b0, head0[5], head0[12:10], head0[6], 2'b00,
                                   rs1_p, 3'b010, rd_p, 7'b0000011};
                    dec_illegal = 1'b0;
                end else if (head0[15:13] == 3'b110) begin
                    dec_instr   = {5'b0, head0[5], head0[12], rd_p, rs1_p, 3'b010,
                                   head0[11:10], head0[6], 2'b00, 7'b0100011};
                    dec_illegal = 1'b0;
                end
            end
            2'b01: begin
                unique case (head0[15:13])
                    3'b000: begin
                        dec_instr   = {{7{head0[12]}}, head0[6:2], rd, 3'b000, rd, 7'b0010011};
                        dec_illegal = 1'b0;
                    end
                    3'b001, 3'b101: begin
                        dec_instr   = {head0[12], head0[8], head0[10:9], head0[6], head0[7],
                                       head0[2], head0[11], head0[5:3], head0[12],
                                       {8{head0[12]}}, (head0[15] ? 5'd0 : 5'd1), 7'b1101111};
                        dec_illegal = 1'b0;
                    end
                    3'b100: begin
                        unique case (head0[11:10])
                            2'b00: if (!head0[12]) begin
                                dec_instr   = {7'b0000000, head0[6:2], rs1_p, 3'b101, rs1_p, 7'b0010011};
                                dec_illegal = 1'b0;
                            end
                            2'b01: if (!head0[12]) begin
                                dec_instr   = {7'b0100000, head0[6:2], rs1_p, 3'b101, rs1_p, 7'b0010011};
                                dec_illegal = 1'b0;
                            end
                            2'b10: begin
                                dec_instr   = {{7{head0[12]}}, head0[6:2], rs1_p, 3'b111, rs1_p, 7'b0010011};
                                dec_illegal = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    3'b110, 3'b111: begin
                        dec_instr   = {head0[12], {3{head0[12]}}, head0[6:5], head0[2], 5'd0,
                                       rs1_p, {2'b00, head0[13]}, head0[11:10], head0[4:3],
                                       head0[12], 7'b1100011};
                        dec_illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            2'b10: begin
                if (head0[15:13] == 3'b000 && !head0[12]) begin
                    dec_instr   = {7'b0000000, head0[6:2], rd, 3'b001, rd, 7'b0010011};
                    dec_illegal = 1'b0;
                end else if (head0[15:13] == 3'b100) begin
                    if (rs2 == 5'd0) begin
                        if (rd != 5'd0) begin
                            dec_instr   = {12'd0, rd, 3'b000, (head0[12] ? 5'd1 : 5'd0), 7'b1100111};
                            dec_illegal = 1'b0;
                        end
                    end else begin
                        dec_instr   = {7'b0000000, rs2, (head0[12] ? rd : 5'd0), 3'b000, rd, 7'b0110011};
                        dec_illegal = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Storage carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (fetch_fire) begin
            if (skip_lo) begin
                hw_buf[wr_ptr] <= fetch_data_i[31:16];
            end else begin
                hw_buf[wr_ptr]          <= fetch_data_i[15:0];
                hw_buf[wr_ptr + PW'(1)] <= fetch_data_i[31:16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pc      <= RESET_PC;
            skip_lo <= RESET_PC[1];
        end else if (redirect_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pc      <= redirect_pc_i & ~32'h1;
            skip_lo <= redirect_pc_i[1];
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop_n);
            count  <= count + CW'(push_n) - CW'(pop_n);
            if (pop_fire) pc <= pc + (head_is_c ? 32'd2 : 32'd4);
            if (fetch_fire) skip_lo <= 1'b0;
        end
    end

endmodule
